// File: rtl/calc_pkg.sv
// Shared op codes, ASCII constants and FSM encoding for the calculator result transmitter.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_DOT   = 8'h2E;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SIGN,
      ST_INT,
      ST_DOT,
      ST_FRAC1,
      ST_FRAC2,
      ST_REP,
      ST_TERM
   } state_t;

   function automatic logic [7:0] digit_char(input logic [3:0] value);
      return CH_ZERO + {4'h0, value};
   endfunction

endpackage

// File: rtl/calc_fmt_lut.sv
// Combinational decode of one calculator result word into the characters and
// flags that steer the frame sequencer.
module calc_fmt_lut
   import calc_pkg::*;
(
   input  logic [1:0] op,
   input  logic [3:0] y,
   input  logic       yrep,
   output logic       need_sign,
   output logic [7:0] int_char,
   output logic       is_err,
   output logic       has_frac,
   output logic [7:0] frac_char1,
   output logic [7:0] frac_char2,
   output logic       need_rep
);

   always_comb begin
      need_sign  = 1'b0;
      int_char   = CH_ZERO;
      is_err     = 1'b0;
      has_frac   = 1'b0;
      frac_char1 = CH_ZERO;
      frac_char2 = CH_ZERO;
      need_rep   = 1'b0;

      case (op)
         OP_ADD, OP_MUL: begin
            if (y > 4'd9) begin
               is_err = 1'b1;
            end else begin
               int_char = digit_char(y);
            end
         end
         OP_SUB: begin
            // y2 is a don't-care; a negative zero prints as plain "0"
            int_char  = digit_char({2'b00, y[1:0]});
            need_sign = y[3] && (y[1:0] != 2'b00);
         end
         OP_DIV: begin
            int_char = digit_char({2'b00, y[3:2]});
            has_frac = 1'b1;
            case (y[1:0])
               2'b00: begin
                  frac_char1 = digit_char(4'd0);
                  frac_char2 = digit_char(4'd0);
               end
               2'b01: begin
                  frac_char1 = yrep ? digit_char(4'd3) : digit_char(4'd2);
                  frac_char2 = yrep ? digit_char(4'd3) : digit_char(4'd5);
                  need_rep   = yrep;
               end
               2'b10: begin
                  frac_char1 = yrep ? digit_char(4'd6) : digit_char(4'd5);
                  frac_char2 = yrep ? digit_char(4'd6) : digit_char(4'd0);
                  need_rep   = yrep;
               end
               default: begin
                  frac_char1 = digit_char(4'd7);
                  frac_char2 = digit_char(4'd5);
               end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/calc_result_tx.sv
// Captures one calculator result word and streams it out as an ASCII frame
// over a valid/ready byte interface.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for a result word, in_ready high
// SIGN     | presenting '-'
// INT      | presenting integer digit (or error char)
// DOT      | presenting '.'
// FRAC1    | presenting first fraction digit
// FRAC2    | presenting second fraction digit
// REP      | presenting recurring marker
// TERM     | presenting frame terminator, tx_last high
module calc_result_tx
   import calc_pkg::*;
#(
   parameter logic [7:0] TERM_CHAR = 8'h0A,
   parameter logic [7:0] REP_CHAR  = 8'h7E,
   parameter logic [7:0] ERR_CHAR  = 8'h3F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_op,
   input  logic [3:0] in_y,
   input  logic       in_yrep,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_last,
   output logic       busy
);

   state_t     state;
   state_t     state_n;
   logic [1:0] op_q;
   logic [3:0] y_q;
   logic       yrep_q;

   logic [1:0] sel_op;
   logic [3:0] sel_y;
   logic       sel_yrep;

   logic       need_sign;
   logic [7:0] int_char;
   logic       is_err;
   logic       has_frac;
   logic [7:0] frac_char1;
   logic [7:0] frac_char2;
   logic       need_rep;

   logic       take_in;
   logic       advance;
   logic       tx_valid_n;
   logic [7:0] tx_data_n;
   logic       tx_last_n;

   // In IDLE the decoder looks at the live inputs so the first byte can be
   // registered in the same edge that captures the word.
   assign sel_op   = (state == ST_IDLE) ? in_op   : op_q;
   assign sel_y    = (state == ST_IDLE) ? in_y    : y_q;
   assign sel_yrep = (state == ST_IDLE) ? in_yrep : yrep_q;

   calc_fmt_lut u_fmt (
      .op         (sel_op),
      .y          (sel_y),
      .yrep       (sel_yrep),
      .need_sign  (need_sign),
      .int_char   (int_char),
      .is_err     (is_err),
      .has_frac   (has_frac),
      .frac_char1 (frac_char1),
      .frac_char2 (frac_char2),
      .need_rep   (need_rep)
   );

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign take_in  = in_valid && in_ready;
   assign advance  = tx_valid && tx_ready;

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (take_in) state_n = need_sign ? ST_SIGN : ST_INT;
         ST_SIGN:  if (advance) state_n = ST_INT;
         ST_INT:   if (advance) state_n = has_frac ? ST_DOT : ST_TERM;
         ST_DOT:   if (advance) state_n = ST_FRAC1;
         ST_FRAC1: if (advance) state_n = ST_FRAC2;
         ST_FRAC2: if (advance) state_n = need_rep ? ST_REP : ST_TERM;
         ST_REP:   if (advance) state_n = ST_TERM;
         ST_TERM:  if (advance) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase

      tx_data_n = 8'h00;
      case (state_n)
         ST_SIGN:  tx_data_n = CH_MINUS;
         ST_INT:   tx_data_n = is_err ? ERR_CHAR : int_char;
         ST_DOT:   tx_data_n = CH_DOT;
         ST_FRAC1: tx_data_n = frac_char1;
         ST_FRAC2: tx_data_n = frac_char2;
         ST_REP:   tx_data_n = REP_CHAR;
         ST_TERM:  tx_data_n = TERM_CHAR;
         default:  tx_data_n = 8'h00;
      endcase

      tx_valid_n = (state_n != ST_IDLE);
      tx_last_n  = (state_n == ST_TERM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         op_q     <= 2'b00;
         y_q      <= 4'h0;
         yrep_q   <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         tx_last  <= 1'b0;
      end else begin
         state    <= state_n;
         tx_valid <= tx_valid_n;
         tx_data  <= tx_data_n;
         tx_last  <= tx_last_n;
         if (take_in) begin
            op_q   <= in_op;
            y_q    <= in_y;
            yrep_q <= in_yrep;
         end
      end
   end

endmodule

// File: tb/tb_calc_result_tx.sv
// Randomized and directed bench for calc_result_tx against a string-level
// reference model of the expected ASCII frames.
module tb_calc_result_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic [3:0] in_y;
   logic       in_yrep;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       busy;

   int         compared   = 0;
   int         mismatched = 0;
   logic [7:0] exp_q[$];

   calc_result_tx dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_y     (in_y),
      .in_yrep  (in_yrep),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference: the printed text of the result, built with plain arithmetic.
   function automatic void build_expected(input logic [1:0] op, input logic [3:0] y,
                                          input logic yrep);
      int v;
      int mag;
      int ip;
      int fq;
      int f;
      exp_q.delete();
      v = int'(y);
      if (op == 2'b00 || op == 2'b10) begin
         if (v > 9) exp_q.push_back(8'h3F);
         else       exp_q.push_back(8'(48 + v));
      end else if (op == 2'b01) begin
         mag = v % 4;
         if (v >= 8 && mag != 0) exp_q.push_back(8'h2D);
         exp_q.push_back(8'(48 + mag));
      end else begin
         ip = v / 4;
         fq = v % 4;
         exp_q.push_back(8'(48 + ip));
         exp_q.push_back(8'h2E);
         if (yrep && fq == 1) begin
            exp_q.push_back(8'h33); exp_q.push_back(8'h33); exp_q.push_back(8'h7E);
         end else if (yrep && fq == 2) begin
            exp_q.push_back(8'h36); exp_q.push_back(8'h36); exp_q.push_back(8'h7E);
         end else begin
            f = fq * 25;
            exp_q.push_back(8'(48 + f / 10));
            exp_q.push_back(8'(48 + f % 10));
         end
      end
      exp_q.push_back(8'h0A);
   endfunction

   // Called at the negedge just after capture; leaves us at the negedge after the last handshake.
   task automatic drain(input string name, input int max_stall, input int forced_idx);
      int stall;
      int n;
      n = exp_q.size();
      compared++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL %s busy_flags: got in_ready=%b busy=%b want 0/1", name, in_ready, busy);
      end
      for (int i = 0; i < n; i++) begin
         stall = (i == forced_idx) ? 3 : int'($urandom_range(max_stall, 0));
         for (int s = 0; s < stall; s++) begin
            tx_ready = 1'b0;
            if (i == forced_idx) begin
               in_valid = 1'b1;
               in_op    = 2'($urandom);
               in_y     = 4'($urandom);
            end
            compared++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
               mismatched++;
               $display("FAIL %s hold byte%0d: got v=%b d=%h want v=1 d=%h",
                        name, i, tx_valid, tx_data, exp_q[i]);
            end
            @(negedge clk);
         end
         in_valid = 1'b0;
         tx_ready = 1'b1;
         compared++;
         if (tx_valid !== 1'b1 || tx_data !== exp_q[i] || tx_last !== (i == n - 1)) begin
            mismatched++;
            $display("FAIL %s byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     name, i, tx_valid, tx_data, tx_last, exp_q[i], (i == n - 1));
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      compared++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL %s end_of_frame: got in_ready=%b busy=%b tx_valid=%b want 1/0/0",
                  name, in_ready, busy, tx_valid);
      end
   endtask

   task automatic run_frame(input logic [1:0] op, input logic [3:0] y, input logic yrep,
                            input int max_stall, input int forced_idx, input string name);
      build_expected(op, y, yrep);
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL %s ready_before: got %b want 1", name, in_ready);
      end
      in_valid = 1'b1;
      in_op    = op;
      in_y     = y;
      in_yrep  = yrep;
      tx_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_op    = 2'($urandom);
      in_y     = 4'($urandom);
      in_yrep  = 1'($urandom);
      drain(name, max_stall, forced_idx);
      @(negedge clk);
      compared++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL %s idle_after: got tx_valid=%b busy=%b want 0/0", name, tx_valid, busy);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_op    = 2'b00;
      in_y     = 4'h0;
      in_yrep  = 1'b0;
      tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_last !== 1'b0 ||
          busy !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_state: got v=%b d=%h l=%b busy=%b rdy=%b want 0/00/0/0/1",
                  tx_valid, tx_data, tx_last, busy, in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_frame(2'b00, 4'b0110, 1'b0, 0, -1, "add_3p3");
      run_frame(2'b01, 4'b1010, 1'b0, 0, -1, "sub_1m3");
      run_frame(2'b01, 4'b0010, 1'b0, 0, -1, "sub_3m1");
      run_frame(2'b01, 4'b1100, 1'b0, 0, -1, "sub_negzero");
      run_frame(2'b10, 4'b1001, 1'b0, 0, -1, "mul_3x3");
      run_frame(2'b00, 4'b1100, 1'b0, 0, -1, "add_err");
      run_frame(2'b11, 4'b0110, 1'b0, 0, -1, "div_3d2");
      run_frame(2'b11, 4'b0010, 1'b1, 0, -1, "div_2d3");
      run_frame(2'b11, 4'b1111, 1'b1, 0, -1, "div_rep_ignored");
      run_frame(2'b00, 4'b0101, 1'b1, 0, -1, "add_rep_ignored");
   endtask

   task automatic test_backpressure();
      // Stall three cycles on the '.' byte while poking in_valid.
      run_frame(2'b11, 4'b0110, 1'b0, 0, 1, "bp_div_dot");
      run_frame(2'b11, 4'b0001, 1'b1, 0, 4, "bp_div_rep");
   endtask

   task automatic test_back_to_back();
      build_expected(2'b10, 4'b0100, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b10;
      in_y     = 4'b0100;
      in_yrep  = 1'b0;
      @(negedge clk);
      // Next word held valid across the whole frame, including the TERM handshake.
      in_op    = 2'b01;
      in_y     = 4'b1011;
      in_yrep  = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         compared++;
         if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
            mismatched++;
            $display("FAIL b2b_first byte%0d: got v=%b d=%h want v=1 d=%h",
                     i, tx_valid, tx_data, exp_q[i]);
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      compared++;
      if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_gap: got tx_valid=%b in_ready=%b want 0/1", tx_valid, in_ready);
      end
      build_expected(2'b01, 4'b1011, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      drain("b2b_second", 0, -1);
   endtask

   task automatic test_reset_mid_frame();
      build_expected(2'b01, 4'b1010, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_y     = 4'b1010;
      in_yrep  = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         compared++;
         if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
            mismatched++;
            $display("FAIL rstmid byte%0d: got v=%b d=%h want v=1 d=%h",
                     i, tx_valid, tx_data, exp_q[i]);
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
      rst      = 1'b1;
      #1;
      compared++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_last !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL rstmid_async: got v=%b busy=%b l=%b rdy=%b want 0/0/0/1",
                  tx_valid, busy, tx_last, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      run_frame(2'b00, 4'b0100, 1'b0, 0, -1, "rstmid_clean");
   endtask

   task automatic test_random();
      logic [1:0] op;
      logic [3:0] y;
      logic       yrep;
      for (int k = 0; k < 40; k++) begin
         op   = 2'($urandom);
         y    = 4'($urandom);
         yrep = 1'($urandom);
         run_frame(op, y, yrep, 2, -1, $sformatf("rand%0d_op%0d_y%0d_r%0d", k, op, y, yrep));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
